// File: rtl/fb_dbuf_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pkg : shared types and helpers for the double-buffered framebuffer |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package fb_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      CLEAR  = 3'd1,
      IDLE   = 3'd2,
      DRAW   = 3'd3,
      FLUSH1 = 3'd4,
      FLUSH2 = 3'd5
   } phase_t;

   localparam logic c_MODE_GREY  = 1'b0;
   localparam logic c_MODE_ZONED = 1'b1;

   function automatic int unsigned fb_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned h_res);
      return row * h_res + col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_dbuf_ctrl_bram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_bram : single-port frame store, synchronous read, write-first      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fb_bram #(
   parameter int DEPTH = 16,
   parameter int CW    = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  logic [CW-1:0] wdata,
   output logic [CW-1:0] rdata
);

   logic [CW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         r_mem[addr] <= wdata;
      if (en)
         rdata <= we ? wdata : r_mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/fb_dbuf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_dbuf_ctrl : double-buffered framebuffer with clear/draw/swap FSM   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fb_dbuf_ctrl
   import fb_pkg::*;
#(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int CW        = 4,
   parameter int SPLIT_ROW = 120,
   parameter int DEPTH     = H_RES * V_RES,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            w_addr,
   input  logic [CW-1:0]            color_in,
   input  logic                     en_w,
   input  logic                     en_r,
   input  logic [$clog2(V_RES)-1:0] row,
   input  logic [$clog2(H_RES)-1:0] col,
   input  logic                     vggo,
   input  logic                     halt,
   input  logic                     mod_zoned,
   output logic [CW-1:0]            red_out,
   output logic [CW-1:0]            green_out,
   output logic [CW-1:0]            blue_out,
   output logic                     ready,
   output logic                     front_sel,
   output logic                     clearing
);

   localparam int            c_RW   = $clog2(V_RES);
   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   phase_t          r_phase, w_phase_nxt;
   logic [AW-1:0]   r_clear_addr;
   logic            r_go_pend, r_vggo_q, r_halt_q, r_front_sel;
   logic            w_vggo_rise, w_halt_rise, w_last, w_enter_draw;
   logic            w_wr_ok, w_oob;
   logic [AW-1:0]   w_raddr;
   logic [CW-1:0]   w_ram_rd [2];
   logic [CW-1:0]   w_pix;
   logic            r1_valid, r1_oob, r1_mode, r1_sel;
   logic [c_RW-1:0] r1_row;
   logic [CW-1:0]   r_red, r_green, r_blue;

   assign w_vggo_rise  = vggo & ~r_vggo_q;
   assign w_halt_rise  = halt & ~r_halt_q;
   assign w_last       = (r_clear_addr == c_LAST);
   assign ready        = (r_phase == DRAW);
   assign clearing     = (r_phase == INIT) || (r_phase == CLEAR);
   assign front_sel    = r_front_sel;
   assign w_enter_draw = (w_phase_nxt == DRAW) && (r_phase != DRAW);
   assign w_wr_ok      = en_w && ready && (int'(w_addr) < DEPTH);
   assign w_raddr      = AW'(fb_addr(32'(row), 32'(col), H_RES));
   // INIT is wiping the front store too, so nothing read then is meaningful
   assign w_oob        = (int'(row) >= V_RES) || (int'(col) >= H_RES) || (r_phase == INIT);

   always_comb begin
      w_phase_nxt = r_phase;
      case (r_phase)
         INIT:    if (w_last) w_phase_nxt = IDLE;
         CLEAR:   if (w_last) w_phase_nxt = r_go_pend ? DRAW : IDLE;
         IDLE:    if (w_vggo_rise || r_go_pend) w_phase_nxt = DRAW;
         DRAW:    if (w_halt_rise) w_phase_nxt = FLUSH1;
         FLUSH1:  w_phase_nxt = FLUSH2;
         FLUSH2:  w_phase_nxt = CLEAR;
         default: w_phase_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase      <= INIT;
         r_clear_addr <= '0;
         r_go_pend    <= 1'b0;
         r_vggo_q     <= 1'b0;
         r_halt_q     <= 1'b0;
         r_front_sel  <= 1'b0;
      end else begin
         r_phase      <= w_phase_nxt;
         r_vggo_q     <= vggo;
         r_halt_q     <= halt;
         r_clear_addr <= (clearing && !w_last) ? r_clear_addr + 1'b1 : '0;
         if (w_enter_draw)
            r_go_pend <= 1'b0;
         else if (w_vggo_rise && (r_phase inside {INIT, CLEAR, FLUSH1, FLUSH2}))
            r_go_pend <= 1'b1;
         if (r_phase == FLUSH2)
            r_front_sel <= ~r_front_sel;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_store
      logic          w_back, w_we, w_en;
      logic [AW-1:0] w_addr_mux;
      logic [CW-1:0] w_wdata;

      // store A (i=0) is the back store when front_sel=1
      assign w_back = (r_front_sel == (i == 0));

      always_comb begin
         w_addr_mux = w_raddr;
         w_we       = 1'b0;
         w_en       = 1'b0;
         w_wdata    = color_in;
         if ((r_phase == INIT) || ((r_phase == CLEAR) && w_back)) begin
            w_addr_mux = r_clear_addr;
            w_we       = 1'b1;
            w_wdata    = '0;
         end else if (w_back) begin
            w_addr_mux = w_addr;
            w_we       = w_wr_ok;
         end else begin
            w_en       = en_r;
         end
      end

      fb_bram #(.DEPTH(DEPTH), .CW(CW), .AW(AW)) u_ram (
         .clk   (clk),
         .we    (w_we),
         .en    (w_en),
         .addr  (w_addr_mux),
         .wdata (w_wdata),
         .rdata (w_ram_rd[i])
      );
   end

   assign w_pix = r1_oob ? '0 : w_ram_rd[r1_sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_oob   <= 1'b0;
         r1_mode  <= c_MODE_GREY;
         r1_sel   <= 1'b0;
         r1_row   <= '0;
         r_red    <= '0;
         r_green  <= '0;
         r_blue   <= '0;
      end else begin
         r1_valid <= en_r;
         r1_oob   <= w_oob;
         r1_mode  <= mod_zoned;
         r1_sel   <= r_front_sel;
         r1_row   <= row;
         if (r1_valid) begin
            if (r1_mode == c_MODE_GREY) begin
               r_red   <= w_pix;
               r_green <= w_pix;
               r_blue  <= w_pix;
            end else if (int'(r1_row) <= SPLIT_ROW) begin
               r_red   <= w_pix;
               r_green <= '0;
               r_blue  <= '0;
            end else begin
               r_red   <= '0;
               r_green <= w_pix;
               r_blue  <= '0;
            end
         end
      end
   end

   assign red_out   = r_red;
   assign green_out = r_green;
   assign blue_out  = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_fb_dbuf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fb_dbuf_ctrl : randomized bench against a frame-level model        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_fb_dbuf_ctrl;

   localparam int H = 8, V = 4, CW = 4, SPLIT = 1, DEPTH = 32, AW = 5;
   localparam int M_INIT = 0, M_CLEAR = 1, M_IDLE = 2, M_DRAW = 3, M_DRAIN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] w_addr = '0;
   logic [CW-1:0] color_in = '0;
   logic          en_w = 1'b0, en_r = 1'b0, vggo = 1'b0, halt = 1'b0, mod_zoned = 1'b0;
   logic [1:0]    row = '0;
   logic [2:0]    col = '0;
   logic [CW-1:0] red_out, green_out, blue_out;
   logic          ready, front_sel, clearing;

   always #5 clk = ~clk;

   fb_dbuf_ctrl #(.H_RES(H), .V_RES(V), .CW(CW), .SPLIT_ROW(SPLIT)) dut (
      .clk(clk), .rst(rst), .w_addr(w_addr), .color_in(color_in),
      .en_w(en_w), .en_r(en_r), .row(row), .col(col),
      .vggo(vggo), .halt(halt), .mod_zoned(mod_zoned),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .ready(ready), .front_sel(front_sel), .clearing(clearing)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame-level model: whole stores, wholesale clears, swap counted from halt
   int            m_mode, m_left;
   bit            m_front, m_pend, m_vq, m_hq, m_started = 1'b0;
   logic [CW-1:0] m_store [2][DEPTH];
   bit            s1_valid, s1_zoned;
   int            s1_row;
   logic [CW-1:0] s1_pix;
   logic [3*CW-1:0] m_rgb;

   initial begin : p_model
      bit vr, hr, old_pend;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_mode = M_INIT; m_left = DEPTH; m_front = 0; m_pend = 0;
            m_vq = 0; m_hq = 0; s1_valid = 0; s1_pix = '0; m_rgb = '0;
            for (int s = 0; s < 2; s++)
               for (int a = 0; a < DEPTH; a++) m_store[s][a] = '0;
            m_started = 1'b1;
         end else begin
            vr = vggo && !m_vq;
            hr = halt && !m_hq;
            m_vq = vggo;
            m_hq = halt;
            if (s1_valid) begin
               if (!s1_zoned)          m_rgb = {s1_pix, s1_pix, s1_pix};
               else if (s1_row <= SPLIT) m_rgb = {s1_pix, 4'h0, 4'h0};
               else                    m_rgb = {4'h0, s1_pix, 4'h0};
            end
            s1_valid = en_r;
            if (en_r) begin
               s1_row   = int'(row);
               s1_zoned = mod_zoned;
               s1_pix   = (m_mode == M_INIT || int'(row) >= V || int'(col) >= H) ? 4'h0
                          : m_store[m_front][int'(row) * H + int'(col)];
            end
            if (m_mode == M_DRAW && en_w && int'(w_addr) < DEPTH)
               m_store[!m_front][w_addr] = color_in;
            case (m_mode)
               M_INIT: begin
                  if (vr) m_pend = 1;
                  m_left--;
                  if (m_left == 0) m_mode = M_IDLE;
               end
               M_CLEAR: begin
                  old_pend = m_pend;
                  if (vr) m_pend = 1;
                  m_left--;
                  if (m_left == 0) begin
                     if (old_pend) begin m_mode = M_DRAW; m_pend = 0; end
                     else m_mode = M_IDLE;
                  end
               end
               M_IDLE: if (vr || m_pend) begin m_mode = M_DRAW; m_pend = 0; end
               M_DRAW: if (hr) begin m_mode = M_DRAIN; m_left = 2; end
               default: begin
                  if (vr) m_pend = 1;
                  m_left--;
                  if (m_left == 0) begin
                     m_front = !m_front;
                     for (int a = 0; a < DEPTH; a++) m_store[!m_front][a] = '0;
                     m_mode = M_CLEAR;
                     m_left = DEPTH;
                  end
               end
            endcase
         end
      end
   end

   initial begin : p_compare
      forever begin
         @(negedge clk);
         if (m_started) begin
            check("ready", int'(ready), int'(m_mode == M_DRAW));
            check("clearing", int'(clearing), int'(m_mode == M_INIT || m_mode == M_CLEAR));
            check("front_sel", int'(front_sel), int'(m_front));
            check("rgb", int'({red_out, green_out, blue_out}), int'(m_rgb));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_all();
      en_r = 1'b1;
      for (int r = 0; r < V; r++)
         for (int c = 0; c < H; c++) begin
            row = 2'(r);
            col = 3'(c);
            tick();
         end
      en_r = 1'b0;
      tick();
      tick();
   endtask

   task automatic read_px(input int r, input int c, output logic [11:0] v);
      row = 2'(r);
      col = 3'(c);
      en_r = 1'b1;
      tick();
      en_r = 1'b0;
      tick();
      v = {red_out, green_out, blue_out};
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready && k < 200) begin tick(); k++; end
      check("wait_ready", int'(ready), 1);
   endtask

   task automatic count_init(input string name);
      int n = 0;
      while (clearing && n < 100) begin tick(); n++; end
      check(name, n, 32);
      check({name, "_ready"}, int'(ready), 0);
   endtask

   task automatic pulse_halt();
      halt = 1'b1;
      tick();
      halt = 1'b0;
   endtask

   initial begin : p_stim
      logic [11:0] v;
      int k;
      repeat (3) tick();
      check("rst_rgb", int'({red_out, green_out, blue_out}), 0);
      check("rst_clearing", int'(clearing), 1);
      rst = 1'b0;
      count_init("init_len");
      read_all();

      // first frame: single pixel, then swap
      vggo = 1'b1; tick(); vggo = 1'b0;
      check("draw_ready", int'(ready), 1);
      en_w = 1'b1; w_addr = 5'd5; color_in = 4'hF; tick(); en_w = 1'b0;
      pulse_halt();
      tick();
      check("swap_h2", int'(front_sel), 0);
      tick();
      check("swap_h3", int'(front_sel), 1);
      read_px(0, 5, v);
      check("px05_white", int'(v), 12'hFFF);

      // second frame: vggo during the sweep, early write dropped
      vggo = 1'b1; tick(); vggo = 1'b0;
      en_w = 1'b1; w_addr = 5'd3; color_in = 4'h7; tick(); en_w = 1'b0;
      wait_ready();
      read_px(0, 5, v);
      check("old_front_05", int'(v), 12'hFFF);
      read_px(0, 3, v);
      check("dropped_03", int'(v), 0);
      read_all();
      en_w = 1'b1; color_in = 4'h9; w_addr = 5'd8; tick();
      w_addr = 5'd16; tick(); en_w = 1'b0;
      pulse_halt();
      tick(); tick();
      check("swap2", int'(front_sel), 0);
      mod_zoned = 1'b1;
      read_px(1, 0, v);
      check("zone_red", int'(v), 12'h900);
      read_px(2, 0, v);
      check("zone_green", int'(v), 12'h090);
      mod_zoned = 1'b0;
      read_all();
      k = 0;
      while (clearing && k < 100) begin tick(); k++; end
      check("wait_idle", int'(clearing), 0);
      pulse_halt();
      repeat (5) tick();
      check("idle_halt_noswap", int'(front_sel), 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         vggo      = ($urandom_range(0, 15) == 0);
         halt      = ($urandom_range(0, 25) == 0);
         en_w      = 1'($urandom);
         w_addr    = 5'($urandom);
         color_in  = 4'($urandom);
         en_r      = 1'($urandom);
         row       = 2'($urandom);
         col       = 3'($urandom);
         mod_zoned = 1'($urandom);
         tick();
      end
      vggo = 0; halt = 0; en_w = 0; en_r = 0; mod_zoned = 0;
      tick();

      // reset in the middle of a clear sweep
      vggo = 1'b1; tick(); vggo = 1'b0;
      wait_ready();
      en_w = 1'b1; w_addr = 5'd5; color_in = 4'hA; tick(); en_w = 1'b0;
      pulse_halt();
      tick(); tick();
      repeat (10) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      count_init("reinit_len");
      read_px(0, 5, v);
      check("reinit_05", int'(v), 0);
      read_all();
      vggo = 1'b1; tick(); vggo = 1'b0;
      wait_ready();
      pulse_halt();
      repeat (3) tick();
      read_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
